// File: rtl/axi_fifo_manager_if.sv
// AXI4-Lite bus bundle between the FIFO-driven manager and a subordinate.
// The master modport is the initiator side; the slave modport mirrors it.
interface axi_fifo_manager_if #(
   parameter int A = 16,
   parameter int D = 32
);
   logic [A-1:0]   awaddr;
   logic [2:0]     awprot;
   logic           awvalid;
   logic           awready;
   logic [D-1:0]   wdata;
   logic [D/8-1:0] wstrb;
   logic           wvalid;
   logic           wready;
   logic [1:0]     bresp;
   logic           bvalid;
   logic           bready;
   logic [A-1:0]   araddr;
   logic [2:0]     arprot;
   logic           arvalid;
   logic           arready;
   logic [D-1:0]   rdata;
   logic [1:0]     rresp;
   logic           rvalid;
   logic           rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input  bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input  rdata, rresp, rvalid, output rready
   );

   modport slave (
      input  awaddr, awprot, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input  araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/axi_fifo_manager.sv
// Pops command words and runs each as one AXI4-Lite write or read, one at a time.
// Read results (and optionally write acks) are pushed into the response FIFO.
module axi_fifo_manager #(
   parameter int AXI_ADDR_WIDTH = 16,
   parameter int AXI_DATA_WIDTH = 32,
   parameter bit WRITE_ACK      = 1'b0
) (
   input  logic                                   aclk,
   input  logic                                   aresetn,
   input  logic [AXI_ADDR_WIDTH+AXI_DATA_WIDTH:0] cmd_rd_data_i,
   input  logic                                   cmd_empty_i,
   output logic                                   cmd_rd_en_o,
   output logic [AXI_DATA_WIDTH+1:0]              rsp_wr_data_o,
   output logic                                   rsp_wr_en_o,
   input  logic                                   rsp_full_i,
   axi_fifo_manager_if.master                     m_axi,
   output logic                                   busy_o,
   output logic                                   err_sticky_o,
   input  logic                                   err_clear_i,
   output logic [15:0]                            txn_count_o
);
   localparam int A = AXI_ADDR_WIDTH;
   localparam int D = AXI_DATA_WIDTH;

   typedef enum logic [2:0] {
      IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA
   } state_t;

   state_t         state_q;
   logic [A-1:0]   addr_q;
   logic [D-1:0]   wdata_q;
   logic           awvalid_q;
   logic           wvalid_q;
   logic           arvalid_q;
   logic           err_q;
   logic [15:0]    txn_count_q;

   logic           pop;
   logic           aw_done;
   logic           w_done;
   logic           b_hs;
   logic           r_hs;
   logic           err_d;

   assign pop     = aresetn && (state_q == IDLE) && !cmd_empty_i;
   // A channel counts as done once its valid has dropped or it handshakes now.
   assign aw_done = !awvalid_q || m_axi.awready;
   assign w_done  = !wvalid_q  || m_axi.wready;

   assign m_axi.bready = (state_q == WR_RESP) && (!WRITE_ACK || !rsp_full_i);
   assign m_axi.rready = (state_q == RD_DATA) && !rsp_full_i;
   assign b_hs = m_axi.bvalid && m_axi.bready;
   assign r_hs = m_axi.rvalid && m_axi.rready;

   always_comb begin
      err_d = err_q;
      if ((b_hs && m_axi.bresp != 2'b00) || (r_hs && m_axi.rresp != 2'b00))
         err_d = 1'b1;
      else if (err_clear_i)
         err_d = 1'b0;
   end

   always_comb begin
      rsp_wr_en_o   = 1'b0;
      rsp_wr_data_o = '0;
      if (r_hs) begin
         rsp_wr_en_o   = 1'b1;
         rsp_wr_data_o = {m_axi.rresp, m_axi.rdata};
      end else if (b_hs && WRITE_ACK) begin
         rsp_wr_en_o   = 1'b1;
         rsp_wr_data_o = {m_axi.bresp, {D{1'b0}}};
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         err_q       <= 1'b0;
         txn_count_q <= '0;
      end else begin
         err_q <= err_d;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  addr_q  <= cmd_rd_data_i[A+D-1:D];
                  wdata_q <= cmd_rd_data_i[D-1:0];
                  if (cmd_rd_data_i[A+D]) begin
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= WR_ADDR;
                  end else begin
                     arvalid_q <= 1'b1;
                     state_q   <= RD_ADDR;
                  end
               end
            end
            WR_ADDR: begin
               if (awvalid_q && m_axi.awready) awvalid_q <= 1'b0;
               if (wvalid_q && m_axi.wready)   wvalid_q  <= 1'b0;
               if (aw_done && w_done)          state_q   <= WR_RESP;
            end
            WR_RESP: begin
               if (b_hs) begin
                  txn_count_q <= txn_count_q + 16'd1;
                  state_q     <= IDLE;
               end
            end
            RD_ADDR: begin
               if (m_axi.arready) begin
                  arvalid_q <= 1'b0;
                  state_q   <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (r_hs) begin
                  txn_count_q <= txn_count_q + 16'd1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_rd_en_o   = pop;
   assign m_axi.awaddr  = addr_q;
   assign m_axi.araddr  = addr_q;
   assign m_axi.wdata   = wdata_q;
   assign m_axi.awprot  = 3'b000;
   assign m_axi.arprot  = 3'b000;
   assign m_axi.wstrb   = {(D/8){1'b1}};
   assign m_axi.awvalid = awvalid_q;
   assign m_axi.wvalid  = wvalid_q;
   assign m_axi.arvalid = arvalid_q;
   assign busy_o        = (state_q != IDLE);
   assign err_sticky_o  = err_q;
   assign txn_count_o   = txn_count_q;
endmodule
